// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the clock divider and its bench.
//   WIDTH_DEFAULT : default bit width of the reload value / internal count
//   RST_COUNT     : count value held while reset is asserted
//   RST_OUT       : divided-clock level held while reset is asserted
package counter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned RST_COUNT     = 0;
  localparam logic        RST_OUT       = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_if.sv
// counter_if: bundles the reload value and divided clock of one counter.
//   clk    : clock shared with the counter (plain input)
//   load   : half-period reload value, driven by the master
//   out    : divided clock, driven by the slave (the counter side)
// The counter itself keeps flat ports so positional instantiation in the
// order load, clk, rst, out keeps working; this interface is the grouping
// used by surrounding logic and benches, with fields wired to those ports.
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic clk
);

  logic [WIDTH-1:0] load;
  logic             out;

  modport master (input clk, output load, input out);
  modport slave  (input clk, input load, output out);

endinterface : counter_if

// File: rtl/counter.sv
// counter: programmable clock divider.
//   load [WIDTH-1:0] in  : half-period reload value, sampled only when count hits 0
//   clk              in  : sole clock, rising edge
//   rst              in  : asynchronous active-low reset
//   out              out : divided clock, straight from a flop
// Each half-period lasts load+1 cycles: on the edge where count is zero the
// counter reloads and out toggles; otherwise count decrements and out holds.
// Reset parks count at 0, so the first edge after release is a reload edge
// and out rises on it.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] load,
  input  logic             clk,
  input  logic             rst,
  output logic             out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             out_q, out_d;
  logic             count_zero;

  // Zero detect: the reload edge. Because reload happens exactly at zero,
  // the decrement below can never wrap.
  assign count_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    out_d   = out_q;
    if (count_zero) begin
      count_d = load;
      out_d   = ~out_q;
    end else begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= WIDTH'(RST_COUNT);
      out_q   <= RST_OUT;
    end else begin
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for the counter clock divider.
// The stimulus side drives load/rst on falling edges and, from a
// half-period view of the divider (each reload starts a run of load+1
// cycles at the opposite level), pushes the expected out level for each
// upcoming rising edge into a queue. A monitor pops one entry per rising
// edge and compares it with the DUT output.
module tb_counter;
  import counter_pkg::*;

  localparam int unsigned W = WIDTH_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  counter_if #(.WIDTH(W)) cif (.clk(clk));

  counter #(.WIDTH(W)) dut (
    .load (cif.load),
    .clk  (clk),
    .rst  (rst),
    .out  (cif.out)
  );

  always #5 clk = ~clk;

  bit exp_q[$];
  bit model_out = 1'b0;
  bit mon_en    = 1'b0;
  int n_vec     = 0;
  int n_bad     = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Called on a falling edge: apply inputs, extend the expected waveform,
  // then advance to the next falling edge.
  task automatic step(input logic [W-1:0] ld, input logic r);
    cif.load = ld;
    rst      = r;
    if (!r) begin
      exp_q.delete();
      model_out = 1'b0;
      exp_q.push_back(1'b0);
    end else if (exp_q.size() == 0) begin
      // Reload edge: a new half-period of ld+1 cycles at the toggled level.
      model_out = ~model_out;
      repeat (int'(ld) + 1) exp_q.push_back(model_out);
    end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: got out=%b expected an entry", $time, cif.out);
        end else begin
          check("out", cif.out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] ld;
    int           rst_left;
    cif.load = W'(2);
    rst      = 1'b0;
    @(negedge clk);

    // Reset held with a nonzero load: out and count stay at reset values.
    for (int i = 0; i < 5; i++) begin
      step(W'(2), 1'b0);
      check("rst_hold_out", cif.out, RST_OUT);
      check("rst_hold_count_zero", dut.count_q == W'(RST_COUNT), 1'b1);
    end

    // load=0: toggle every edge.
    for (int i = 0; i < 8; i++) step(W'(0), 1'b1);

    // load=2: 3 high / 3 low.
    step(W'(2), 1'b0);
    step(W'(2), 1'b0);
    for (int i = 0; i < 13; i++) step(W'(2), 1'b1);

    // Change load mid-count: current half-period finishes, then 5-cycle runs.
    for (int i = 0; i < 15; i++) step(W'(4), 1'b1);

    // Asynchronous reset between edges while out is high.
    for (int i = 0; i < 20 && !(model_out == 1'b1 && exp_q.size() > 1); i++)
      step(W'(2), 1'b1);
    check("async_rst_precond_out_high", cif.out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out_immediate", cif.out, RST_OUT);
    exp_q.delete();
    model_out = 1'b0;
    exp_q.push_back(1'b0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) step(W'(2), 1'b1);

    // Maximum load: 16-cycle half-periods, no wrap.
    for (int i = 0; i < 50; i++) step(W'(15), 1'b1);

    // Randomized load changes and occasional reset pulses.
    ld       = W'($urandom_range(0, (1 << W) - 1));
    rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ld = W'($urandom_range(0, (1 << W) - 1));
      if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        rst_left--;
        step(ld, 1'b0);
      end else begin
        step(ld, 1'b1);
      end
    end

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_counter
